// File: rtl/player_input_encoder.sv
// player_input_encoder
// Turns one player's six raw push-buttons into a one-hot command, issued at most once per game
// step. Each button is synchronised, debounced and edge-latched; a per-step arbiter picks the
// highest-priority pending press, and an attack cooldown FSM masks attacks for a few steps.
// Optional feature macro: HOLD_REPEAT_EN (held move buttons repeat their command every step).
// Bit map: [0] move_fwd [1] move_back [2] attack_high [3] attack_low [4] defend_high [5] defend_low
module player_input_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,  // stable samples before a level change (>=2)
    parameter int unsigned STEP_CYCLES     = 64,  // clk cycles per game step (>=2)
    parameter int unsigned COOLDOWN_STEPS  = 3    // ticks with attacks masked after an attack (>=1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [5:0] btn_raw,
    output logic [5:0] player_cmd,
    output logic       cmd_valid,
    output logic       cooldown_act
);

    localparam int unsigned NumBtn   = 6;
    localparam int unsigned DbCntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned StepCntW = $clog2(STEP_CYCLES + 1);
    localparam int unsigned CoolCntW = $clog2(COOLDOWN_STEPS + 1);

    localparam logic [DbCntW-1:0]   DbCntLast   = DbCntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [StepCntW-1:0] StepCntLast = StepCntW'(STEP_CYCLES - 1);
    localparam logic [CoolCntW-1:0] CoolLoad    = CoolCntW'(COOLDOWN_STEPS);
    localparam logic [CoolCntW-1:0] CoolLast    = CoolCntW'(1);

    localparam int unsigned BitFwd      = 0;
    localparam int unsigned BitBack     = 1;
    localparam int unsigned BitAtkHigh  = 2;
    localparam int unsigned BitAtkLow   = 3;
    localparam int unsigned BitDefHigh  = 4;
    localparam int unsigned BitDefLow   = 5;

    localparam logic [5:0] AttackMask = 6'b00_1100;

    typedef enum logic [0:0] {
        StRun,
        StCool
    } state_e;

    // Input path
    logic [5:0]        sync1_q;
    logic [5:0]        sync2_q;
    logic [DbCntW-1:0] db_cnt_q [NumBtn];
    logic [DbCntW-1:0] db_cnt_d [NumBtn];
    logic [5:0]        db_level_q;
    logic [5:0]        db_level_d;
    logic [5:0]        db_rise;

    // Step timer
    logic [StepCntW-1:0] step_cnt_q;
    logic [StepCntW-1:0] step_cnt_d;
    logic                tick;

    // Pending presses and arbitration
    logic [5:0] pend_q;
    logic [5:0] pend_d;
    logic [5:0] pend_eff;
    logic [5:0] cand;
    logic [5:0] winner;
    logic       winner_attack;

    // Cooldown FSM
    state_e              state_q;
    logic [CoolCntW-1:0] cool_cnt_q;

    // Two-flop synchroniser on every raw button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive samples that disagree with the level; flip on the last one.
    always_comb begin
        db_level_d = db_level_q;
        db_rise    = '0;
        for (int i = 0; i < NumBtn; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_level_q[i]) begin
                if (db_cnt_q[i] == DbCntLast) begin
                    db_level_d[i] = sync2_q[i];
                    db_rise[i]    = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state; keeps running while disabled so levels stay current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level_q <= '0;
            for (int i = 0; i < NumBtn; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_level_q <= db_level_d;
            for (int i = 0; i < NumBtn; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // Step timer next state: free-running wrap, parked at 0 while disabled.
    always_comb begin
        tick       = enable && (step_cnt_q == StepCntLast);
        step_cnt_d = step_cnt_q + 1'b1;
        if (!enable || tick) begin
            step_cnt_d = '0;
        end
    end

    // Step timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    // Pending presses: sticky until a tick; a rise in the tick cycle survives into the next step.
    always_comb begin
        pend_d = '0;
        if (enable) begin
            pend_d = (tick ? 6'b00_0000 : pend_q) | db_rise;
        end
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

`ifdef HOLD_REPEAT_EN
    // Held move buttons count as pending every step; attacks and defends stay edge-only.
    assign pend_eff = pend_q | {4'b0000, db_level_q[BitBack:BitFwd]};
`else
    assign pend_eff = pend_q;
`endif

    // Priority arbiter: defend_high > defend_low > attack_high > attack_low > single move.
    always_comb begin
        cand   = pend_eff & ~((state_q == StCool) ? AttackMask : 6'b00_0000);
        winner = '0;
        if (cand[BitDefHigh]) begin
            winner[BitDefHigh] = 1'b1;
        end else if (cand[BitDefLow]) begin
            winner[BitDefLow] = 1'b1;
        end else if (cand[BitAtkHigh]) begin
            winner[BitAtkHigh] = 1'b1;
        end else if (cand[BitAtkLow]) begin
            winner[BitAtkLow] = 1'b1;
        end else if (cand[BitFwd] ^ cand[BitBack]) begin
            // Opposing moves cancel; only a lone move direction is issued.
            winner[BitBack:BitFwd] = cand[BitBack:BitFwd];
        end
        winner_attack = |(winner & AttackMask);
    end

    // Cooldown FSM with registered command outputs; disable forces RUN and idles outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            cool_cnt_q   <= '0;
            cooldown_act <= 1'b0;
            player_cmd   <= '0;
            cmd_valid    <= 1'b0;
        end else if (!enable) begin
            state_q      <= StRun;
            cool_cnt_q   <= '0;
            cooldown_act <= 1'b0;
            player_cmd   <= '0;
            cmd_valid    <= 1'b0;
        end else begin
            player_cmd <= tick ? winner : 6'b00_0000;
            cmd_valid  <= tick && (winner != 6'b00_0000);
            if (tick) begin
                case (state_q)
                    StRun: begin
                        if (winner_attack) begin
                            state_q      <= StCool;
                            cool_cnt_q   <= CoolLoad;
                            cooldown_act <= 1'b1;
                        end
                    end
                    StCool: begin
                        // The tick that sees the last count still masks attacks, then leaves.
                        if (cool_cnt_q == CoolLast) begin
                            state_q      <= StRun;
                            cool_cnt_q   <= '0;
                            cooldown_act <= 1'b0;
                        end else begin
                            cool_cnt_q <= cool_cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q      <= StRun;
                        cool_cnt_q   <= '0;
                        cooldown_act <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_input_encoder.sv
// Directed bench for player_input_encoder with DEBOUNCE_CYCLES=4, STEP_CYCLES=8, COOLDOWN_STEPS=2.
// Inputs change 1 time unit after a rising edge; outputs are logged on falling edges.
module tb_player_input_encoder;

    localparam int unsigned Step = 8;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [5:0] btn_raw;
    logic [5:0] player_cmd;
    logic       cmd_valid;
    logic       cooldown_act;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int base  = 0;
    int vbad  = 0;

    logic [5:0] ev_cmd [$];
    int         ev_cyc [$];

    logic [5:0] win_pat  [16];
    logic [5:0] win_exp  [16];
    logic       win_cool [16];

    player_input_encoder #(
        .DEBOUNCE_CYCLES (4),
        .STEP_CYCLES     (8),
        .COOLDOWN_STEPS  (2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .btn_raw      (btn_raw),
        .player_cmd   (player_cmd),
        .cmd_valid    (cmd_valid),
        .cooldown_act (cooldown_act)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Log every cycle that shows a command; flag any cycle where valid and command disagree.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid || (player_cmd != 6'h00)) begin
                ev_cmd.push_back(player_cmd);
                ev_cyc.push_back(cyc);
            end
            if (cmd_valid != (player_cmd != 6'h00)) vbad <= vbad + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_ev();
        ev_cmd.delete();
        ev_cyc.delete();
    endtask

    // Move to the cycle just after the edge that returns the step counter to 0.
    task automatic align_step();
        while (((cyc - base) % Step) != 0) tick_clk(1);
    endtask

    // Each window: 4 cycles pressed, 4 released; its command shows at window end.
    task automatic run_windows(input int n, input string name);
        int         start;
        int         hits;
        logic [5:0] obs;
        clear_ev();
        start = cyc;
        for (int w = 0; w < n; w++) begin
            win_cool[w] = cooldown_act;
            btn_raw = win_pat[w];
            tick_clk(4);
            btn_raw = 6'h00;
            tick_clk(4);
        end
        tick_clk(1);
        hits = 0;
        for (int w = 0; w < n; w++) begin
            obs = 6'h00;
            for (int k = 0; k < ev_cmd.size(); k++) begin
                if (ev_cyc[k] == start + Step * (w + 1)) obs = ev_cmd[k];
            end
            if (win_exp[w] != 6'h00) hits++;
            check_eq($sformatf("%s_w%0d", name, w), 32'(obs), 32'(win_exp[w]));
        end
        check_eq($sformatf("%s_count", name), ev_cmd.size(), hits);
    endtask

    initial begin
        int         first_cyc;
        logic [5:0] first_cmd;
        logic [5:0] last_cmd;
        int         hold_exp;

        rst_n   = 1'b0;
        enable  = 1'b1;
        btn_raw = 6'h00;

        // 1: reset in the middle of a step with every button pending aborts it all
        tick_clk(2);
        rst_n   = 1'b1;
        btn_raw = 6'h3F;
        tick_clk(6);
        #2;
        rst_n   = 1'b0;
        btn_raw = 6'h00;
        #1;
        check_eq("t1_rst_cmd", 32'(player_cmd), 32'h0);
        check_eq("t1_rst_valid", 32'(cmd_valid), 32'h0);
        check_eq("t1_rst_cool", 32'(cooldown_act), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base  = cyc;
        clear_ev();
        tick_clk(5 * Step);
        check_eq("t1_quiet", ev_cmd.size(), 0);

        // 2: 3-cycle bounce never becomes pending
        clear_ev();
        btn_raw[2] = 1'b1;
        tick_clk(3);
        btn_raw = 6'h00;
        tick_clk(3 * Step);
        check_eq("t2_bounce", ev_cmd.size(), 0);

        // 3a: long hold gives a single one-cycle attack at the next tick
        align_step();
        clear_ev();
        first_cyc  = cyc;
        btn_raw[2] = 1'b1;
        tick_clk(20);
        btn_raw = 6'h00;
        tick_clk(10);
        first_cmd = (ev_cmd.size() > 0) ? ev_cmd[0] : 6'h00;
        check_eq("t3_hold_count", ev_cmd.size(), 1);
        check_eq("t3_hold_cmd", 32'(first_cmd), 32'h04);
        check_eq("t3_hold_cyc", (ev_cyc.size() > 0) ? ev_cyc[0] : 0, first_cyc + Step);
        check_eq("t3_cool_over", 32'(cooldown_act), 32'h0);

        // 3b: attack, then one attack press per step; two masked, the third issues
        align_step();
        win_pat[0] = 6'h04; win_exp[0] = 6'h04;
        win_pat[1] = 6'h04; win_exp[1] = 6'h00;
        win_pat[2] = 6'h04; win_exp[2] = 6'h00;
        win_pat[3] = 6'h04; win_exp[3] = 6'h04;
        run_windows(4, "t3_cool");
        check_eq("t3_coolact_w0", 32'(win_cool[0]), 32'h0);
        check_eq("t3_coolact_w1", 32'(win_cool[1]), 32'h1);
        check_eq("t3_coolact_w2", 32'(win_cool[2]), 32'h1);
        check_eq("t3_coolact_w3", 32'(win_cool[3]), 32'h0);

        // 4: priority, cancelling moves, losers cleared, masking falls through to a move
        tick_clk(2 * Step);
        align_step();
        win_pat[0] = 6'h13; win_exp[0] = 6'h10;
        win_pat[1] = 6'h03; win_exp[1] = 6'h00;
        win_pat[2] = 6'h11; win_exp[2] = 6'h10;
        win_pat[3] = 6'h00; win_exp[3] = 6'h00;
        win_pat[4] = 6'h01; win_exp[4] = 6'h01;
        win_pat[5] = 6'h28; win_exp[5] = 6'h20;
        win_pat[6] = 6'h0C; win_exp[6] = 6'h04;
        win_pat[7] = 6'h0A; win_exp[7] = 6'h02;
        run_windows(8, "t4_prio");

        // 5: disable mid-cooldown; nothing issues, FSM returns to RUN, first tick 8 clk later
        check_eq("t5_cool_before", 32'(cooldown_act), 32'h1);
        clear_ev();
        enable     = 1'b0;
        btn_raw[3] = 1'b1;
        tick_clk(40);
        check_eq("t5_dis_cool", 32'(cooldown_act), 32'h0);
        check_eq("t5_dis_cmd", 32'(player_cmd), 32'h0);
        btn_raw = 6'h00;
        tick_clk(Step);
        check_eq("t5_dis_quiet", ev_cmd.size(), 0);
        enable = 1'b1;
        base   = cyc;
        win_pat[0] = 6'h08; win_exp[0] = 6'h08;
        win_pat[1] = 6'h00; win_exp[1] = 6'h00;
        run_windows(2, "t5_reen");

        // 6: holding a move button for five steps
`ifdef HOLD_REPEAT_EN
        hold_exp = 5;
`else
        hold_exp = 1;
`endif
        tick_clk(3 * Step);
        align_step();
        clear_ev();
        btn_raw[1] = 1'b1;
        tick_clk(5 * Step);
        btn_raw = 6'h00;
        tick_clk(10);
        first_cmd = (ev_cmd.size() > 0) ? ev_cmd[0] : 6'h00;
        last_cmd  = (ev_cmd.size() > 0) ? ev_cmd[ev_cmd.size() - 1] : 6'h00;
        check_eq("t6_hold_count", ev_cmd.size(), hold_exp);
        check_eq("t6_hold_first", 32'(first_cmd), 32'h02);
        check_eq("t6_hold_last", 32'(last_cmd), 32'h02);

        check_eq("valid_matches_cmd", vbad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
